// File: rtl/uvmt_axis_st_arb_pkg.sv
// Shared types and helpers for the packet-aware AXI-Stream round-robin arbiter.
// The round-robin search and the configuration check live here so the selector and the top agree.
package uvmt_axis_st_arb_pkg;

  localparam int MAX_PORTS = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Returns the first requester after ptr (ptr+1, ptr+2, ... modulo n),
  // i.e. rotate, priority-encode, un-rotate. Returns 0 when nothing requests.
  function automatic int rr_pick(input logic [MAX_PORTS-1:0] req, input int n, input int ptr);
    int  idx;
    bit  found;
    rr_pick = 0;
    found   = 1'b0;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      if (k <= n) begin
        idx = (ptr + k) % n;
        if (!found && req[idx]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

  function automatic bit cfg_ok(input int num_ports, input int data_w, input int id_w);
    return (num_ports >= 2) && (num_ports <= MAX_PORTS) &&
           (id_w >= $clog2(num_ports)) && ((data_w % 8) == 0) && (data_w > 0);
  endfunction

endpackage

// File: rtl/uvmt_axis_st_rr_sel.sv
// Combinational round-robin selector: picks the first requester after rr_ptr.
module uvmt_axis_st_rr_sel
  import uvmt_axis_st_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ID_W      = 4
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_W-1:0]      rr_ptr,
  output logic [ID_W-1:0]      winner,
  output logic                 any_req
);

  logic [MAX_PORTS-1:0] req_ext;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_PORTS-1:0]   = req;
    winner                   = ID_W'(rr_pick(req_ext, NUM_PORTS, int'(rr_ptr)));
    any_req                  = |req;
  end

endmodule

// File: rtl/uvmt_axis_st_arb.sv
// Packet-aware round-robin arbiter sharing one AXI-Stream output among NUM_PORTS inputs.
// A grant is held until the tlast beat handshakes; one IDLE bubble separates packets.
module uvmt_axis_st_arb
  import uvmt_axis_st_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          in_tvalid,
  output logic [NUM_PORTS-1:0]          in_tready,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_tdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] in_tkeep,
  input  logic [NUM_PORTS-1:0]          in_tlast,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic [DATA_W-1:0]             out_tdata,
  output logic [DATA_W/8-1:0]           out_tkeep,
  output logic                          out_tlast,
  output logic [ID_W-1:0]               out_tid,
  output logic [ID_W-1:0]               grant_o,
  output logic                          busy_o,
  output logic [CNT_W-1:0]              beat_cnt_o,
  output logic [CNT_W-1:0]              pkt_cnt_o
);

  localparam int KEEP_W = DATA_W / 8;

  if (!cfg_ok(NUM_PORTS, DATA_W, ID_W)) begin : g_bad_cfg
    $error("uvmt_axis_st_arb: illegal NUM_PORTS/DATA_W/ID_W combination");
  end

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     winner;
  logic                any_req;
  logic                sel_valid, sel_last, xfer;
  logic [DATA_W-1:0]   sel_data;
  logic [KEEP_W-1:0]   sel_keep;

  uvmt_axis_st_rr_sel #(
    .NUM_PORTS (NUM_PORTS),
    .ID_W      (ID_W)
  ) u_rr_sel (
    .req     (in_tvalid),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Source mux driven by the registered grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_o == ID_W'(i)) begin
        sel_valid = in_tvalid[i];
        sel_last  = in_tlast[i];
        sel_data  = in_tdata[i*DATA_W +: DATA_W];
        sel_keep  = in_tkeep[i*KEEP_W +: KEEP_W];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tkeep  = '0;
    out_tlast  = 1'b0;
    out_tid    = '0;
    in_tready  = '0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = LOCKED;
      end
      LOCKED: begin
        out_tvalid = sel_valid;
        out_tdata  = sel_data;
        out_tkeep  = sel_keep;
        out_tlast  = sel_last;
        out_tid    = grant_o;
        for (int i = 0; i < NUM_PORTS; i++) begin
          in_tready[i] = (grant_o == ID_W'(i)) & out_tready;
        end
        xfer = sel_valid & out_tready;
        if (xfer && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_PORTS - 1);
      grant_o    <= '0;
      beat_cnt_o <= '0;
      pkt_cnt_o  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        grant_o <= winner;
        rr_ptr  <= winner;
      end
      if (xfer) begin
        if (sel_last) begin
          beat_cnt_o <= '0;
          pkt_cnt_o  <= pkt_cnt_o + 1'b1;
        end else if (beat_cnt_o != {CNT_W{1'b1}}) begin
          beat_cnt_o <= beat_cnt_o + 1'b1;
        end
      end
    end
  end

  assign busy_o = (state == LOCKED);

endmodule

// File: tb/tb_uvmt_axis_st_arb.sv
// Directed self-checking bench for uvmt_axis_st_arb (4 ports, 64-bit data, 4-bit counters).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_uvmt_axis_st_arb;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     in_tvalid;
  logic [NP-1:0]     in_tready;
  logic [NP*DW-1:0]  in_tdata;
  logic [NP*DW/8-1:0] in_tkeep;
  logic [NP-1:0]     in_tlast;
  logic              out_tvalid;
  logic              out_tready;
  logic [DW-1:0]     out_tdata;
  logic [DW/8-1:0]   out_tkeep;
  logic              out_tlast;
  logic [IW-1:0]     out_tid;
  logic [IW-1:0]     grant_o;
  logic              busy_o;
  logic [CW-1:0]     beat_cnt_o;
  logic [CW-1:0]     pkt_cnt_o;

  int checks = 0;
  int errors = 0;

  uvmt_axis_st_arb #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .ID_W      (IW),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tdata   (in_tdata),
    .in_tkeep   (in_tkeep),
    .in_tlast   (in_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tlast  (out_tlast),
    .out_tid    (out_tid),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .beat_cnt_o (beat_cnt_o),
    .pkt_cnt_o  (pkt_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic v, input logic [63:0] d, input logic l);
    in_tvalid[p]        = v;
    in_tdata[p*DW +: DW] = d;
    in_tkeep[p*8 +: 8]   = 8'hF0 | 8'(p);
    in_tlast[p]         = l;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tvalid"}, 64'(out_tvalid), 64'd0);
    check({tag, "_tready"}, 64'(in_tready), 64'd0);
    check({tag, "_busy"},   64'(busy_o), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    in_tvalid  = '0;
    in_tdata   = '0;
    in_tkeep   = '0;
    in_tlast   = '0;
    out_tready = 1'b1;

    // Reset state
    tick(); settle();
    check("rst_tvalid", 64'(out_tvalid), 64'd0);
    check("rst_tready", 64'(in_tready), 64'd0);
    check("rst_busy",   64'(busy_o), 64'd0);
    check("rst_grant",  64'(grant_o), 64'd0);
    check("rst_beat",   64'(beat_cnt_o), 64'd0);
    check("rst_pkt",    64'(pkt_cnt_o), 64'd0);
    check("rst_tdata",  out_tdata, 64'd0);
    check("rst_tid",    64'(out_tid), 64'd0);
    reset = 1'b0;

    // Test 1: 3-beat packet on port 2
    tick(); set_port(2, 1'b1, 64'hA0, 1'b0); settle();
    check_idle("t1_arb");
    for (int b = 0; b < 3; b++) begin
      tick(); set_port(2, 1'b1, 64'hA0 + 64'(b), b == 2); settle();
      check("t1_tvalid", 64'(out_tvalid), 64'd1);
      check("t1_tid",    64'(out_tid), 64'd2);
      check("t1_tdata",  out_tdata, 64'hA0 + 64'(b));
      check("t1_tkeep",  64'(out_tkeep), 64'hF2);
      check("t1_tlast",  64'(out_tlast), (b == 2) ? 64'd1 : 64'd0);
      check("t1_tready", 64'(in_tready), 64'b0100);
      check("t1_beat",   64'(beat_cnt_o), 64'(b));
    end
    tick(); set_port(2, 1'b0, 64'h0, 1'b0); settle();
    check_idle("t1_end");
    check("t1_pkt",   64'(pkt_cnt_o), 64'd1);
    check("t1_beat0", 64'(beat_cnt_o), 64'd0);
    check("t1_grant", 64'(grant_o), 64'd2);

    // Test 2: all ports request 1-beat packets after reset -> 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 64'hB0 + 64'(p), 1'b1);
    settle();
    check_idle("t2_arb");
    for (int k = 0; k < 5; k++) begin
      tick(); settle();
      check("t2_tvalid", 64'(out_tvalid), 64'd1);
      check("t2_tid",    64'(out_tid), 64'(k % 4));
      check("t2_tdata",  out_tdata, 64'hB0 + 64'(k % 4));
      check("t2_tready", 64'(in_tready), 64'(1 << (k % 4)));
      tick();
      if (k == 4) in_tvalid = '0;
      settle();
      check_idle("t2_bubble");
    end
    check("t2_pkt", 64'(pkt_cnt_o), 64'd5);

    // Test 3: port 1 4-beat packet, port 3 requests during beat 2
    tick(); set_port(1, 1'b1, 64'hC0, 1'b0); settle();
    check_idle("t3_arb");
    for (int b = 0; b < 4; b++) begin
      tick(); set_port(1, 1'b1, 64'hC0 + 64'(b), b == 3);
      if (b == 1) set_port(3, 1'b1, 64'hD0, 1'b1);
      settle();
      check("t3_tid",    64'(out_tid), 64'd1);
      check("t3_tdata",  out_tdata, 64'hC0 + 64'(b));
      check("t3_tready", 64'(in_tready), 64'b0010);
    end
    tick(); set_port(1, 1'b0, 64'h0, 1'b0); settle();
    check_idle("t3_bubble");
    tick(); settle();
    check("t3_p3_tid",    64'(out_tid), 64'd3);
    check("t3_p3_tdata",  out_tdata, 64'hD0);
    check("t3_p3_tready", 64'(in_tready), 64'b1000);
    tick(); set_port(3, 1'b0, 64'h0, 1'b0); settle();
    check("t3_pkt",   64'(pkt_cnt_o), 64'd7);
    check("t3_grant", 64'(grant_o), 64'd3);

    // Test 4: backpressure for 5 cycles mid-packet on port 0
    tick(); set_port(0, 1'b1, 64'hE0, 1'b0); settle();
    tick(); settle();
    check("t4_tdata0", out_tdata, 64'hE0);
    tick(); set_port(0, 1'b1, 64'hE1, 1'b0); out_tready = 1'b0; settle();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin tick(); settle(); end
      check("t4_hold_tvalid", 64'(out_tvalid), 64'd1);
      check("t4_hold_tdata",  out_tdata, 64'hE1);
      check("t4_hold_tready", 64'(in_tready), 64'd0);
      check("t4_hold_beat",   64'(beat_cnt_o), 64'd1);
    end
    tick(); out_tready = 1'b1; settle();
    check("t4_resume_tready", 64'(in_tready), 64'b0001);
    check("t4_resume_tdata",  out_tdata, 64'hE1);
    tick(); set_port(0, 1'b1, 64'hE2, 1'b1); settle();
    check("t4_last_tdata", out_tdata, 64'hE2);
    check("t4_last_beat",  64'(beat_cnt_o), 64'd2);
    tick(); set_port(0, 1'b0, 64'h0, 1'b0); settle();
    check_idle("t4_end");
    check("t4_pkt",  64'(pkt_cnt_o), 64'd8);
    check("t4_beat", 64'(beat_cnt_o), 64'd0);

    // Test 5: reset during beat 2 of a port-0 packet
    tick(); set_port(0, 1'b1, 64'hF0, 1'b0); settle();
    tick(); settle();
    check("t5_tdata0", out_tdata, 64'hF0);
    tick(); set_port(0, 1'b1, 64'hF1, 1'b0); settle();
    check("t5_beat_pre", 64'(beat_cnt_o), 64'd1);
    check("t5_busy_pre", 64'(busy_o), 64'd1);
    reset = 1'b1;
    #1;
    check_idle("t5_rst");
    check("t5_rst_grant", 64'(grant_o), 64'd0);
    check("t5_rst_beat",  64'(beat_cnt_o), 64'd0);
    check("t5_rst_pkt",   64'(pkt_cnt_o), 64'd0);
    check("t5_rst_tdata", out_tdata, 64'd0);
    tick(); reset = 1'b0; set_port(1, 1'b1, 64'h60, 1'b1); settle();
    check_idle("t5_arb");
    tick(); set_port(0, 1'b1, 64'hF1, 1'b1); settle();
    check("t5_first_tid",   64'(out_tid), 64'd0);
    check("t5_first_tdata", out_tdata, 64'hF1);
    tick(); set_port(0, 1'b0, 64'h0, 1'b0); settle();
    check_idle("t5_bubble");
    tick(); settle();
    check("t5_second_tid",   64'(out_tid), 64'd1);
    check("t5_second_tdata", out_tdata, 64'h60);
    tick(); set_port(1, 1'b0, 64'h0, 1'b0); settle();
    check("t5_pkt", 64'(pkt_cnt_o), 64'd2);

    // Test 6: 20-beat packet on port 2 saturates the 4-bit beat counter
    tick(); set_port(2, 1'b1, 64'h100, 1'b0); settle();
    for (int b = 0; b < 20; b++) begin
      tick(); set_port(2, 1'b1, 64'h100 + 64'(b), b == 19); settle();
      check("t6_tid",  64'(out_tid), 64'd2);
      check("t6_beat", 64'(beat_cnt_o), (b < 15) ? 64'(b) : 64'd15);
    end
    tick(); set_port(2, 1'b0, 64'h0, 1'b0); settle();
    check("t6_beat_clr", 64'(beat_cnt_o), 64'd0);
    check("t6_pkt",      64'(pkt_cnt_o), 64'd3);
    check_idle("t6_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uvmt_axis_st_arb.md
Name: uvmt_axis_st_arb

Overview:
Packet-aware round-robin arbiter that shares one AXI-Stream master channel between NUM_PORTS requesting streams in the self-test DUT.
- Once a port is granted, it owns the output until the beat with tlast completes its handshake. No interleaving of packets.
- Output carries the winning port index on tid so the downstream side and scoreboard can attribute packets.
- Sits between the stimulus-side master interfaces and the single slave interface of the self-test harness.

Parameters:
NUM_PORTS, 4, number of input streams (2..16)
DATA_W, 64, tdata width in bits (multiple of 8)
ID_W, 4, tid width; must satisfy 2**ID_W >= NUM_PORTS
CNT_W, 16, width of the beat counter and packet counter

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
in_tvalid  in  NUM_PORTS  per-port tvalid
in_tready  out  NUM_PORTS  per-port tready
in_tdata  in  NUM_PORTS*DATA_W  packed per-port tdata; port i at [i*DATA_W +: DATA_W]
in_tkeep  in  NUM_PORTS*DATA_W/8  packed per-port tkeep
in_tlast  in  NUM_PORTS  per-port tlast
out_tvalid  out  1  output tvalid
out_tready  in  1  output tready
out_tdata  out  DATA_W  output tdata
out_tkeep  out  DATA_W/8  output tkeep
out_tlast  out  1  output tlast
out_tid  out  ID_W  index of the granted port
grant_o  out  ID_W  current or last granted port index
busy_o  out  1  high while in LOCKED
beat_cnt_o  out  CNT_W  beats transferred in the current packet
pkt_cnt_o  out  CNT_W  total packets completed since reset

Behaviour:
- Reset values (async on reset=1):
  - State IDLE; rr_ptr = NUM_PORTS-1, so port 0 has first priority.
  - All outputs 0: out_tvalid, in_tready, busy_o, grant_o, beat_cnt_o, pkt_cnt_o, and out data/keep/last/tid.
- FSM states: IDLE, LOCKED.
- IDLE:
  - in_tready = 0; out_tvalid = 0.
  - If any in_tvalid is high, select the first requesting port searching rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS.
  - Register it into grant_o, set rr_ptr = winner, go to LOCKED.
  - Arbitration costs exactly 1 cycle: first output beat is visible the cycle after the request is seen.
- LOCKED (g = grant_o):
  - Output is combinational pass-through with zero latency:
    - out_tvalid = in_tvalid[g]
    - out_tdata, out_tkeep and out_tlast are port g's fields.
    - out_tid = g.
    - in_tready[g] = out_tready; all other in_tready = 0.
  - When out_tvalid & out_tready are both high, a beat is transferred:
    - Without tlast: beat_cnt_o increments, saturating at all-ones.
    - With tlast: go to IDLE, clear beat_cnt_o to 0, increment pkt_cnt_o (wraps modulo 2**CNT_W).
  - The cycle after tlast is always an IDLE bubble. No back-to-back grant within the same cycle.
- Non-granted inputs must see tready = 0 at all times.
  - A requester that drops tvalid before being granted is simply skipped.
- AXI-S rule: once the output presents tvalid with out_tready low, it holds stable. The arbiter never revokes a grant mid-packet, so stability is inherited from the granted source.
- Out-of-protocol source: if the granted source drops tvalid mid-packet, the arbiter stays LOCKED indefinitely (no timeout), waiting for it.
- Fairness: with all ports continuously requesting, grants rotate 0,1,2,...,NUM_PORTS-1,0,...
- Reset asserted mid-packet:
  - Immediately returns to IDLE with rr_ptr = NUM_PORTS-1.
  - The partial packet is abandoned; no tlast is fabricated.
- Tie-breaking comes only from rr_ptr ordering; no fixed priority.

Decomposition:
- Package uvmt_axis_st_arb_pkg holds:
  - State enum (IDLE, LOCKED).
  - Function for the round-robin next-index search (rotate request vector by rr_ptr+1, priority-encode, un-rotate).
  - Localparam checks ID_W >= $clog2(NUM_PORTS) and DATA_W % 8 == 0.
- One sub-module is natural: uvmt_axis_st_rr_sel. It is purely combinational, taking req vector and rr_ptr and producing winner index and any_req. It is reused by the scoreboard model.

Test Plan:
- Single packet on port 2 (3 beats, tdata 0xA0..0xA2), out_tready=1 -> 1 cycle IDLE, then 3 consecutive output beats with tid=2 and tlast on 0xA2; pkt_cnt_o=1; beat_cnt_o returns to 0.
- All 4 ports request simultaneously with 1-beat packets -> output tid order 0,1,2,3,0; one bubble between packets; each in_tready pulses only while that port holds the grant.
- Port 1 sends a 4-beat packet and port 3 requests at beat 2 -> port 1 completes all 4 beats uninterrupted; port 3 is granted the cycle after the IDLE bubble.
- Backpressure: out_tready low for 5 cycles mid-packet -> out_tvalid/out_tdata held stable, in_tready[g]=0, beat_cnt_o unchanged; transfer resumes when out_tready rises.
- Reset pulsed during beat 2 of a port-0 packet -> outputs 0 asynchronously; after release with ports 0 and 1 requesting, port 0 is granted first.
- Saturation: CNT_W=4, 20-beat packet -> beat_cnt_o sticks at 15 until tlast, then clears to 0.
